key_event_decoder: RTL and testbench

//   Downstream of the key debouncer. Consumes its debounced edge pulse
//   (key_flag) and level (key_state), and classifies each gesture as a

---
 rtl/key_event_decoder.sv | 132 +++++++++++++
 tb/tb_key_event_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into short / double / long (+ optional repeat) events.
// Latency: events are registered, one cycle after the deciding edge or counter value; no backpressure.
// Optional auto-repeat in HOLD is built only when KEY_REPEAT_EN is defined.
module key_event_decoder #(
    parameter int CNT_W      = 27,
    parameter int LONG_CYC   = 75_000_000,
    parameter int DBL_CYC    = 15_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic evt_short,
    output logic evt_double,
    output logic evt_long,
    output logic evt_repeat,
    output logic busy
);

    // Timing constants must fit the counter and leave room for a terminal value.
    if (LONG_CYC < 2 || DBL_CYC < 2 || REPEAT_CYC < 2 ||
        LONG_CYC > 2**CNT_W || DBL_CYC > 2**CNT_W || REPEAT_CYC > 2**CNT_W) begin : g_bad_param
        $error("key_event_decoder: timing parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        PRESS1 = 5'b00010,
        WAIT2  = 5'b00100,
        PRESS2 = 5'b01000,
        HOLD   = 5'b10000
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             prs_edge, rel_edge;
    logic             short_nxt, double_nxt, long_nxt;

    assign prs_edge = key_flag & ~key_state;
    assign rel_edge = key_flag &  key_state;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
    logic repeat_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (state == IDLE) ? cnt : cnt + 1'b1;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_nxt = 1'b0;
`endif
        // Edges are tested before timeouts so an edge on the terminal count wins.
        case (state)
            IDLE: begin
                if (prs_edge) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (rel_edge) begin
                    state_nxt = WAIT2;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = HOLD;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                if (prs_edge) begin
                    state_nxt = PRESS2;
                end else if (cnt == DBL_LAST) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (rel_edge) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = HOLD;
                    long_nxt  = 1'b1;
                end
            end
            HOLD: begin
                if (rel_edge) begin
                    state_nxt = IDLE;
`ifdef KEY_REPEAT_EN
                end else if (cnt == REP_LAST) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            evt_short  <= 1'b0;
            evt_double <= 1'b0;
            evt_long   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            evt_short  <= short_nxt;
            evt_double <= double_nxt;
            evt_long   <= long_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) evt_repeat <= 1'b0;
        else     evt_repeat <= repeat_nxt;
    end
`else
    assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: deadline-based reference model, gesture table, directed corners, random edges.
module tb_key_event_decoder;

    localparam int LONG = 100;
    localparam int DBL  = 30;
    localparam int REP  = 20;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    localparam int PH_IDLE = 0, PH_DOWN1 = 1, PH_GAP = 2, PH_DOWN2 = 3, PH_HELD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_flag = 1'b0;
    logic key_state = 1'b1;
    logic evt_short, evt_double, evt_long, evt_repeat, busy;

    key_event_decoder #(
        .CNT_W(8), .LONG_CYC(LONG), .DBL_CYC(DBL), .REPEAT_CYC(REP)
    ) dut (
        .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(key_state),
        .evt_short(evt_short), .evt_double(evt_double), .evt_long(evt_long),
        .evt_repeat(evt_repeat), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // Reference model: each gesture phase holds an absolute edge number (deadline) at which it times out.
    int   cyc = 0;
    int   m_phase = PH_IDLE;
    int   m_dl = 0;
    logic m_short = 1'b0, m_double = 1'b0, m_long = 1'b0, m_rep = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        m_short  <= 1'b0;
        m_double <= 1'b0;
        m_long   <= 1'b0;
        m_rep    <= 1'b0;
        if (rst) begin
            m_phase <= PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (key_flag && !key_state) begin
                    m_phase <= PH_DOWN1; m_dl <= cyc + 1 + LONG;
                end
                PH_DOWN1: if (key_flag && key_state) begin
                    m_phase <= PH_GAP; m_dl <= cyc + 1 + DBL;
                end else if (cyc + 1 == m_dl) begin
                    m_phase <= PH_HELD; m_dl <= cyc + 1 + REP; m_long <= 1'b1;
                end
                PH_GAP: if (key_flag && !key_state) begin
                    m_phase <= PH_DOWN2; m_dl <= cyc + 1 + LONG;
                end else if (cyc + 1 == m_dl) begin
                    m_phase <= PH_IDLE; m_short <= 1'b1;
                end
                PH_DOWN2: if (key_flag && key_state) begin
                    m_phase <= PH_IDLE; m_double <= 1'b1;
                end else if (cyc + 1 == m_dl) begin
                    m_phase <= PH_HELD; m_dl <= cyc + 1 + REP; m_long <= 1'b1;
                end
                default: if (key_flag && key_state) begin
                    m_phase <= PH_IDLE;
                end else if (REP_ON && cyc + 1 == m_dl) begin
                    m_dl <= cyc + 1 + REP; m_rep <= 1'b1;
                end
            endcase
        end
    end

    int total = 0;
    int bad = 0;
    int first_kind, first_edge, ev_cnt, rep_cnt, last_rep, long_edge;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_log();
        first_kind = 0; first_edge = 0; ev_cnt = 0;
        rep_cnt = 0; last_rep = 0; long_edge = 0;
    endtask

    // Advance one cycle, compare all outputs with the model, and log events.
    task automatic step();
        logic [4:0] got, expv;
        int kind;
        @(negedge clk);
        got  = {evt_short, evt_double, evt_long, evt_repeat, busy};
        expv = {m_short, m_double, m_long, m_rep, (m_phase != PH_IDLE)};
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL model edge=%0d got=%b expected=%b (short,double,long,repeat,busy)", cyc, got, expv);
        end
        kind = evt_short ? 1 : evt_double ? 2 : evt_long ? 3 : evt_repeat ? 4 : 0;
        if (kind != 0) begin
            ev_cnt++;
            if (first_kind == 0) begin first_kind = kind; first_edge = cyc; end
        end
        if (evt_repeat) begin rep_cnt++; last_rep = cyc; end
        if (evt_long) long_edge = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic ks);
        key_flag = 1'b1; key_state = ks;
        step();
        key_flag = 1'b0;
    endtask

    typedef struct {
        int h1; int gap; int h2;   // hold, release-to-press gap (0 = single), second hold
        int kind; int off; int cnt; // first event kind, its edge offset from the press, event count
    } gest_t;

    gest_t tbl[11];
    int p;
    logic lvl;
    int den, r;

    initial begin
        tbl[0]  = '{10,  0,  0,   1, 40,  1};
        tbl[1]  = '{10,  5,  10,  2, 25,  1};
        tbl[2]  = '{1,   0,  0,   1, 31,  1};
        tbl[3]  = '{100, 0,  0,   1, 130, 1};
        tbl[4]  = '{10,  30, 5,   2, 45,  1};
        tbl[5]  = '{10,  31, 5,   1, 40,  2};
        tbl[6]  = '{120, 0,  0,   3, 100, 1};
        tbl[7]  = '{10,  5,  100, 2, 115, 1};
        tbl[8]  = '{10,  5,  101, 3, 115, 1};
        tbl[9]  = '{99,  0,  0,   1, 129, 1};
        tbl[10] = '{101, 0,  0,   3, 100, 1};

        clear_log();
        idle(3);
        check("reset_outputs", int'({evt_short, evt_double, evt_long, evt_repeat, busy}), 0);
        rst = 1'b0;
        idle(2);
        check("idle_busy", int'(busy), 0);

        for (int t = 0; t < 11; t++) begin
            clear_log();
            p = cyc + 1;
            pulse(1'b0);
            idle(tbl[t].h1 - 1);
            pulse(1'b1);
            if (tbl[t].gap > 0) begin
                idle(tbl[t].gap - 1);
                pulse(1'b0);
                idle(tbl[t].h2 - 1);
                pulse(1'b1);
            end
            idle(160);
            check($sformatf("gest%0d_kind", t), first_kind, tbl[t].kind);
            check($sformatf("gest%0d_offset", t), first_edge - p, tbl[t].off);
            check($sformatf("gest%0d_count", t), ev_cnt, tbl[t].cnt);
        end

        // Long hold with auto-repeat (when built in), released just after the tenth tick.
        clear_log();
        p = cyc + 1;
        pulse(1'b0);
        idle(300);
        pulse(1'b1);
        idle(40);
        check("hold_long_edge", long_edge - p, LONG);
        check("hold_repeat_count", rep_cnt, REP_ON ? 10 : 0);
        check("hold_last_repeat", REP_ON ? last_rep - p : 0, REP_ON ? 300 : 0);
        check("hold_event_count", ev_cnt, REP_ON ? 11 : 1);

        // Reset in the middle of the first press abandons the gesture.
        clear_log();
        pulse(1'b0);
        idle(50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_outputs", int'({evt_short, evt_double, evt_long, evt_repeat, busy}), 0);
        idle(120);
        pulse(1'b1);
        idle(40);
        check("rst_mid_no_event", ev_cnt, 0);

        // Duplicate press while held is ignored and does not restart timing.
        clear_log();
        p = cyc + 1;
        pulse(1'b0);
        idle(40);
        pulse(1'b0);
        idle(80);
        check("dup_press_long_edge", long_edge - p, LONG);
        check("dup_press_kind", first_kind, 3);
        pulse(1'b1);
        idle(40);

        // Random edges, including inconsistent ones and occasional resets.
        lvl = 1'b1;
        for (int b = 0; b < 30; b++) begin
            den = int'($urandom_range(4, 150));
            for (int i = 0; i < 150; i++) begin
                r = int'($urandom_range(0, den - 1));
                key_flag = 1'b0;
                rst = ($urandom_range(0, 999) == 0);
                if (r == 0) begin
                    lvl = ~lvl; key_state = lvl; key_flag = 1'b1;
                end else if (r == 1 && $urandom_range(0, 3) == 0) begin
                    key_state = lvl; key_flag = 1'b1;
                end
                step();
            end
        end
        key_flag = 1'b0;
        rst = 1'b0;
        idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
